// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the clock mode/set controller.
// Field widths match the HH:MM:SS counter datapath.
package clock_ctrl_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  function automatic state_t next_mode(input state_t s);
    unique case (s)
      RUN:      next_mode = SET_HOUR;
      SET_HOUR: next_mode = SET_MIN;
      SET_MIN:  next_mode = SET_SEC;
      default:  next_mode = RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronised button level.
// Previous sample resets high so a button held through reset is not an event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b1;
    else      prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM and time-setting load generator for the HH:MM:SS datapath.
// Handles inc auto-repeat and idle timeout back to RUN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS    = 2,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic [SEC_W-1:0]  sec_q,
  input  logic [MIN_W-1:0]  min_q,
  input  logic [HOUR_W-1:0] hour_q,
  output logic              sec_ci,
  output logic              sec_ld,
  output logic              min_ld,
  output logic              hour_ld,
  output logic [SEC_W-1:0]  sec_d,
  output logic [MIN_W-1:0]  min_d,
  output logic [HOUR_W-1:0] hour_d,
  output logic [1:0]        mode_o
);

  localparam int HW = $clog2(HOLD_TICKS + 2);
  localparam int IW = $clog2(TIMEOUT_TICKS + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_TICKS);

  state_t state, state_nxt;
  logic mode_ev, inc_ev;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idle_cnt;
  logic rpt, do_ld, timeout;
  logic [SEC_W-1:0]  sec_nxt;
  logic [MIN_W-1:0]  min_nxt;
  logic [HOUR_W-1:0] hour_nxt;

  btn_edge u_mode (
    .clk  (clk),
    .rst  (rst),
    .btn  (mode_btn),
    .rise (mode_ev)
  );

  btn_edge u_inc (
    .clk  (clk),
    .rst  (rst),
    .btn  (inc_btn),
    .rise (inc_ev)
  );

  assign sec_ci = rst & tick & (state == RUN);
  assign mode_o = state;

  // Repeat fires on the tick that brings hold_cnt to (or keeps it at) the limit.
  assign rpt = tick & inc_btn & ~inc_ev & (hold_cnt >= HOLD_PRE);
  assign do_ld = (inc_ev | rpt) & (state != RUN) & ~mode_ev;
  assign timeout = (state != RUN) & (idle_cnt == IDLE_MAX) & ~do_ld;

  assign hour_nxt = (hour_q >= HOUR_MAX) ? '0 : hour_q + 1'b1;
  assign min_nxt  = (min_q >= MIN_MAX) ? '0 : min_q + 1'b1;
  assign sec_nxt  = '0;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      mode_ev: state_nxt = next_mode(state);
      timeout: state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (inc_ev || !inc_btn || timeout) begin
      hold_cnt <= '0;
    end else if (tick && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (mode_ev || inc_ev || inc_btn || state_nxt != state) begin
      idle_cnt <= '0;
    end else if (tick && state != RUN && idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hour_ld <= 1'b0;
      min_ld  <= 1'b0;
      sec_ld  <= 1'b0;
      hour_d  <= '0;
      min_d   <= '0;
      sec_d   <= '0;
    end else begin
      hour_ld <= 1'b0;
      min_ld  <= 1'b0;
      sec_ld  <= 1'b0;
      hour_d  <= '0;
      min_d   <= '0;
      sec_d   <= '0;
      if (do_ld) begin
        unique case (state)
          SET_HOUR: begin
            hour_ld <= 1'b1;
            hour_d  <= hour_nxt;
          end
          SET_MIN: begin
            min_ld <= 1'b1;
            min_d  <= min_nxt;
          end
          SET_SEC: begin
            sec_ld <= 1'b1;
            sec_d  <= sec_nxt;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and random checks of clock_set_ctrl against a behavioural model
// that also plays the role of the external HH:MM:SS counters.
module tb_clock_set_ctrl;

  localparam int HOLD    = 2;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst, tick, mode_btn, inc_btn;
  logic [5:0] sec_q, min_q;
  logic [4:0] hour_q;
  logic sec_ci, sec_ld, min_ld, hour_ld;
  logic [5:0] sec_d, min_d;
  logic [4:0] hour_d;
  logic [1:0] mode_o;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .HOLD_TICKS    (HOLD),
    .TIMEOUT_TICKS (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec_q    (sec_q),
    .min_q    (min_q),
    .hour_q   (hour_q),
    .sec_ci   (sec_ci),
    .sec_ld   (sec_ld),
    .min_ld   (min_ld),
    .hour_ld  (hour_ld),
    .sec_d    (sec_d),
    .min_d    (min_d),
    .hour_d   (hour_d),
    .mode_o   (mode_o)
  );

  int nerr = 0;
  int nchk = 0;
  int n_min_ld = 0;
  int n_any_ld = 0;
  int n_ci = 0;

  // Reference model: mode index, last button samples, hold/idle tick counts
  int m_mode = 0;
  int m_last_mode = 1;
  int m_last_inc = 1;
  int m_hold = 0;
  int m_idle = 0;
  int e_field = 0;
  int e_val = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit t, input bit mb, input bit ib,
                            input bit r);
    bit mpress, ipress, repeat_now, load_now, expired;
    int new_mode;
    e_field = 0;
    e_val = 0;
    if (!r) begin
      m_mode = 0;
      m_last_mode = 1;
      m_last_inc = 1;
      m_hold = 0;
      m_idle = 0;
      return;
    end
    mpress = mb && m_last_mode == 0;
    ipress = ib && m_last_inc == 0;
    repeat_now = t && ib && !ipress && (m_hold + 1 >= HOLD);
    load_now = (ipress || repeat_now) && m_mode != 0 && !mpress;
    if (load_now) begin
      e_field = m_mode;
      case (m_mode)
        1: e_val = (hour_q > 23) ? 0 : (hour_q + 1) % 24;
        2: e_val = (min_q > 59) ? 0 : (min_q + 1) % 60;
        default: e_val = 0;
      endcase
    end
    expired = m_mode != 0 && m_idle >= TIMEOUT && !load_now;
    new_mode = mpress ? (m_mode + 1) % 4 : (expired ? 0 : m_mode);
    if (ipress || !ib || expired) m_hold = 0;
    else if (t) m_hold = (m_hold >= HOLD) ? HOLD : m_hold + 1;
    if (mpress || ipress || ib || new_mode != m_mode) m_idle = 0;
    else if (t && m_mode != 0) m_idle = (m_idle >= TIMEOUT) ? TIMEOUT : m_idle + 1;
    m_mode = new_mode;
    m_last_mode = mb;
    m_last_inc = ib;
  endtask

  task automatic step(input bit t, input bit mb, input bit ib, input bit r);
    int p_field, p_val;
    bit e_ci;
    tick = t;
    mode_btn = mb;
    inc_btn = ib;
    rst = r;
    @(negedge clk);
    e_ci = r && t && m_mode == 0;
    chk("sec_ci", sec_ci, e_ci);
    p_field = e_field;
    p_val = e_val;
    model_edge(t, mb, ib, r);
    @(posedge clk);
    #1;
    if (p_field == 1) hour_q = 5'(p_val);
    if (p_field == 2) min_q = 6'(p_val);
    if (p_field == 3) sec_q = 6'(p_val);
    else if (e_ci) sec_q = (sec_q == 59) ? 6'd0 : sec_q + 6'd1;
    chk("mode_o", mode_o, m_mode);
    chk("hour_ld", hour_ld, e_field == 1);
    chk("min_ld", min_ld, e_field == 2);
    chk("sec_ld", sec_ld, e_field == 3);
    chk("hour_d", hour_d, (e_field == 1) ? e_val : 0);
    chk("min_d", min_d, (e_field == 2) ? e_val : 0);
    chk("sec_d", sec_d, (e_field == 3) ? e_val : 0);
    if (min_ld === 1'b1) n_min_ld++;
    if ((hour_ld | min_ld | sec_ld) === 1'b1) n_any_ld++;
    if (e_ci) n_ci++;
  endtask

  task automatic press_mode();
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    bit mb, ib, t, r;
    tick = 0; mode_btn = 1; inc_btn = 1; rst = 0;
    sec_q = 6'd10; min_q = 6'd20; hour_q = 5'd5;
    @(posedge clk);
    #1;

    // reset with both buttons held high
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("rst_mode", mode_o, 0);
    n_any_ld = 0;
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    chk("held_no_mode", mode_o, 0);
    chk("held_no_ld", 8'(n_any_ld), 0);
    step(0, 0, 0, 1);

    // RUN: three ticks give three carries
    n_ci = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
    end
    chk("run_ci_count", 8'(n_ci), 3);
    press_mode();
    chk("set_hour_mode", mode_o, 1);
    n_ci = 0;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("frozen_ci", 8'(n_ci), 0);

    // SET_HOUR wrap and normal increment
    hour_q = 5'd23;
    step(0, 0, 1, 1);
    chk("hour_wrap_ld", hour_ld, 1);
    chk("hour_wrap_d", hour_d, 0);
    step(0, 0, 0, 1);
    chk("hour_ld_one", hour_ld, 0);
    hour_q = 5'd7;
    step(0, 0, 1, 1);
    chk("hour_7_d", hour_d, 8);
    step(0, 0, 0, 1);

    // SET_MIN auto-repeat from 59
    press_mode();
    chk("set_min_mode", mode_o, 2);
    min_q = 6'd59;
    n_min_ld = 0;
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 1);
      step(0, 0, 1, 1);
    end
    chk("rpt_count", 8'(n_min_ld), 5);
    chk("rpt_min_q", 8'(min_q), 4);
    step(0, 0, 0, 1);

    // SET_SEC timeout after ten idle ticks
    press_mode();
    chk("set_sec_mode", mode_o, 3);
    n_any_ld = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
    end
    chk("timeout_mode", mode_o, 0);
    chk("timeout_no_ld", 8'(n_any_ld), 0);

    // simultaneous mode + inc: mode wins, no load
    step(0, 1, 1, 1);
    chk("simul_mode", mode_o, 1);
    chk("simul_no_ld", hour_ld, 0);
    step(0, 0, 0, 1);

    // reset right after an inc press in SET_MIN
    press_mode();
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("abort_min_ld", min_ld, 0);
    chk("abort_mode", mode_o, 0);
    step(0, 0, 0, 1);

    // random stimulus against the model
    mb = 0; ib = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) mb = !mb;
      if ($urandom_range(0, 7) == 0) ib = !ib;
      t = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) hour_q = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) min_q = 6'($urandom_range(0, 63));
      step(t, mb, ib, r);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and time-setting controller for the HH:MM:SS clock datapath. It gates the 1 Hz tick into the seconds counter while running. In set modes it drives load/data pulses into the hour (mod-24), minute (mod-60) and second (mod-60) counters, based on two button inputs. Counter outputs feed back as inputs, so the block computes each incremented value. Seconds-to-minutes and minutes-to-hours carries are chained externally and are not touched here.

## Interface
Parameters:
- HOLD_TICKS, 2: ticks inc_btn must stay high after its rising edge before auto-repeat starts.
- TIMEOUT_TICKS, 10: idle ticks in any set mode before automatic return to RUN.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- tick  input  1  1 Hz enable pulse, one clk wide.
- mode_btn  input  1  debounced, synchronised level.
- inc_btn  input  1  debounced, synchronised level.
- sec_q  input  6  current seconds value.
- min_q  input  6  current minutes value.
- hour_q  input  5  current hours value.
- sec_ci  output  1  carry-in to seconds counter; combinational.
- sec_ld, min_ld, hour_ld  output  1 each  load strobes; registered.
- sec_d  output  6  load data for seconds; registered.
- min_d  output  6  load data for minutes; registered.
- hour_d  output  5  load data for hours; registered.
- mode_o  output  2  current state: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.

## Operation
- Button events are rising edges: btn high while its previous-sample register is low. Previous-sample registers reset to 1, so a button held through reset produces no event.
- FSM on a mode event: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- sec_ci = tick & (state==RUN). Time is frozen in every set mode.
- An inc event (or auto-repeat) in a set mode issues one load on the counter for that mode:
  - SET_HOUR: hour_d = (hour_q==23) ? 0 : hour_q+1.
  - SET_MIN: min_d = (min_q==59) ? 0 : min_q+1.
  - SET_SEC: sec_d = 0, so seconds are cleared.
- Increments are computed at full field width. Out-of-range inputs (hour_q>23, min_q>59) load 0.
- inc events in RUN are ignored.
- Auto-repeat:
  - hold_cnt clears on an inc event and on inc_btn low.
  - It increments on each tick while inc_btn is high, saturating at HOLD_TICKS.
  - Each tick with hold_cnt==HOLD_TICKS and inc_btn high generates one load.
- Timeout:
  - idle_cnt counts ticks in set modes.
  - It clears on any button event, on any state change, and whenever inc_btn is high.
  - When idle_cnt reaches TIMEOUT_TICKS, the state becomes RUN on the next edge and both counters clear.
- Simultaneous events:
  - Mode event and inc event (or repeat) in the same cycle: the mode event wins and no load is issued.
  - Timeout and inc event in the same cycle: the inc event wins.
- Reset:
  - state=RUN; all ld=0, all d=0, hold_cnt=0, idle_cnt=0.
  - sec_ci=0 whenever rst is low.
  - Reset mid-operation (e.g. in SET_MIN) aborts any pending load.

## Timing
- Event sampled at edge N → ld strobe high for exactly one cycle after edge N. d is valid in that same cycle. The counter loads at edge N+1.
- d is computed from the *_q values sampled at edge N.
- ld strobes never assert in two consecutive cycles. The minimum spacing is one tick, or two cycles per button edge.
- State changes at edge N when the mode event is sampled at edge N.
- A tick coinciding with a RUN→SET_HOUR event still produces sec_ci in that cycle, because the state is still RUN.
- Output values outside a strobe cycle: ld=0 and d=0.

## Structure
- Package clock_ctrl_pkg holds:
  - the state encoding type (2-bit enum, values as for mode_o);
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - field widths 6/6/5.
- Sub-module btn_edge: one previous-sample flop plus the rising-edge detect. It takes clk and rst (the flop resets to 1) and is instantiated once each for mode_btn and inc_btn.
- The FSM, repeat counter, timeout counter and load registers live in the top module.

## Test plan
- Reset with both buttons held high → mode_o=0, all ld=0, sec_ci=0. After rst goes high, no mode change or load occurs until the buttons are released and re-pressed.
- RUN, 3 ticks → sec_ci pulses 3 times, coincident with tick. A mode press → mode_o=1; subsequent ticks give sec_ci=0.
- SET_HOUR with hour_q=23, inc press → hour_ld=1 for one cycle with hour_d=0. With hour_q=7 → hour_d=8.
- SET_MIN with min_q=59, inc held 5 ticks (HOLD_TICKS=2), min_q fed back from a model counter → min_ld pulses once on the edge, then on ticks 2, 3, 4 and 5; min_q goes 59→0→1→2→3→4.
- SET_SEC, no buttons for 10 ticks → mode_o returns to 0 one cycle after the 10th tick, with no loads. Mode and inc pressed in the same cycle → state advances and no ld is issued.
- SET_MIN, inc press followed by rst low in the next cycle → min_ld=0 and mode_o=0 after that edge.
